lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have parameter CNT_W, default 14, meaning bin counter width (126x126 = 15876 samples fit).
REQ-002 SHALL have parameter NBIN, default 256, meaning histogram bin count; it SHALL equal 2^8.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port lbp_valid  in  1  LBP sample qualifier from the upstream LBP stage.
REQ-006 SHALL have port lbp_addr  in  14  pixel address {y[6:0],x[6:0]} of the sample.
REQ-007 SHALL have port lbp_data  in  8  LBP code; selects the bin.
REQ-008 SHALL have port finish  in  1  upstream end-of-frame; level, may stay high indefinitely.
REQ-009 SHALL have port in_ready  out  1  high when samples are being accepted.
REQ-010 SHALL have port hist_valid  out  1  readout word valid.
REQ-011 SHALL have port hist_ready  in  1  downstream accepts readout word.
REQ-012 SHALL have port hist_bin  out  8  bin index of readout word.
REQ-013 SHALL have port hist_count  out  CNT_W  count of that bin.
REQ-014 SHALL have port hist_done  out  1  one-cycle pulse after bin 255 is accepted.
REQ-015 SHALL have port err  out  1  sticky error flag: dropped sample, border address, or saturation.

Function
REQ-016 SHALL implement states CLEAR, ACC, DRAIN, READ, DONE.
REQ-017 CLEAR SHALL write zero to bins 0..255, one per cycle (256 cycles), then go to ACC; in_ready=0.
REQ-018 ACC SHALL set in_ready=1 and accept a sample on every cycle with lbp_valid=1.
REQ-019 Accepted sample SHALL pass a 2-stage read-modify-write pipeline: S1 reads bin[lbp_data]; S2 writes value+1.
REQ-020 If the S1 bin equals the S2 bin, S1 SHALL use the S2 write value (forwarding); back-to-back identical codes SHALL each count once.
REQ-021 Increment SHALL saturate at 2^CNT_W-1 and set err.
REQ-022 Sample with x or y equal to 0 or 127 SHALL be ignored (no count) and set err.
REQ-023 Sample arriving with lbp_valid=1 while in_ready=0 SHALL be dropped and set err.
REQ-024 In ACC, the first cycle with finish=1 SHALL still accept that cycle's sample if lbp_valid=1, then go to DRAIN; later finish/lbp_valid cycles SHALL be ignored.
REQ-025 DRAIN SHALL last 2 cycles (pipeline flush), then go to READ with read index 0.
REQ-026 READ SHALL present hist_valid=1 one cycle after entering; hist_bin, hist_count SHALL hold stable while hist_ready=0.
REQ-027 On hist_valid&hist_ready, the bin SHALL be cleared to zero and the index incremented; next word valid on the following cycle at the earliest.
REQ-028 After bin 255 is accepted: hist_done=1 for one cycle, state DONE.
REQ-029 DONE SHALL stay until finish=0 is seen, then go to ACC (bins already zero; no CLEAR).
REQ-030 err SHALL clear only on reset.

Reset
REQ-031 reset=1 at any clock edge, including mid-ACC or mid-READ, SHALL abort the operation and enter CLEAR next cycle.
REQ-032 Reset values: in_ready=0, hist_valid=0, hist_bin=0, hist_count=0, hist_done=0, err=0, read index=0.
REQ-033 Bin storage SHALL have no reset; it is zeroed only by CLEAR and read-clear.

Verification
REQ-034 Reset, wait 256 cycles -> in_ready rises on cycle 257; readout of an empty frame yields 256 words of count 0, then hist_done.
REQ-035 Send 15876 samples over interior pixels, all code 8'h55, lbp_valid every cycle -> bin 0x55 = 15876, all other bins 0, err=0.
REQ-036 Send code 0x12 on three consecutive cycles, then 0x12,0x34,0x12 -> bin 0x12 = 5, bin 0x34 = 1 (forwarding).
REQ-037 Assert finish with lbp_valid=1 held for 20 cycles, code 0x07 -> bin 0x07 incremented exactly once.
REQ-038 During READ, toggle hist_ready randomly -> 256 words in order 0..255, data stable while stalled; a second frame starts from zero.
REQ-039 Send addr {7'd0,7'd5}, drive lbp_valid during CLEAR, drive CNT_W=4 with 16 identical codes -> no count for the border/dropped samples, bin saturates at 15, err=1.

Source files
------------

// File: rtl/lbp_hist.sv
// LBP code histogram.
// Clears 256 bins, then counts LBP codes from interior pixels through a
// 2-stage read-modify-write pipeline with forwarding. On finish it drains
// the pipeline and streams every bin out, clearing each bin as it is read,
// so the next frame starts from zero.
module lbp_hist #(
  parameter int CNT_W = 14,
  parameter int NBIN  = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             in_ready,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done,
  output logic             err
);

  typedef enum logic [2:0] {CLEAR, ACC, DRAIN, READ, DONE} state_t;

  localparam logic [7:0]       LAST_BIN = 8'(NBIN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t             r_state;
  logic [7:0]         r_idx;
  logic               r_drain_cnt;
  logic               r_in_ready;
  logic               r_hist_valid;
  logic [7:0]         r_hist_bin;
  logic [CNT_W-1:0]   r_hist_count;
  logic               r_hist_done;
  logic               r_err;
  logic               r_s1_valid;
  logic [7:0]         r_s1_bin;
  logic               r_s2_valid;
  logic [7:0]         r_s2_bin;
  logic [CNT_W-1:0]   r_s2_val;
  logic [CNT_W-1:0]   r_mem [NBIN];

  logic [6:0]         w_x;
  logic [6:0]         w_y;
  logic               w_border;
  logic               w_accept;
  logic [CNT_W-1:0]   w_s1_rd;
  logic               w_s1_sat;
  logic [CNT_W-1:0]   w_s1_inc;
  logic [7:0]         w_idx_next;
  logic               w_we;
  logic [7:0]         w_waddr;
  logic [CNT_W-1:0]   w_wdata;

  assign w_x        = lbp_addr[6:0];
  assign w_y        = lbp_addr[13:7];
  assign w_border   = (w_x == 7'd0) || (w_x == 7'd127) ||
                      (w_y == 7'd0) || (w_y == 7'd127);
  assign w_accept   = r_in_ready && lbp_valid;
  assign w_idx_next = r_idx + 8'd1;

  // S1 read: take the value S2 is about to write when both target the same bin.
  assign w_s1_rd  = (r_s2_valid && (r_s2_bin == r_s1_bin)) ? r_s2_val : r_mem[r_s1_bin];
  assign w_s1_sat = &w_s1_rd;
  assign w_s1_inc = w_s1_sat ? w_s1_rd : w_s1_rd + ONE;

  // Single bin write port: pipeline S2, CLEAR sweep, or read-clear on handshake.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_we    = 1'b0;
    w_waddr = r_idx;
    w_wdata = '0;
    if (r_s2_valid) begin
      w_we    = 1'b1;
      w_waddr = r_s2_bin;
      w_wdata = r_s2_val;
    end else if (r_state == CLEAR) begin
      w_we = 1'b1;
    end else if (r_state == READ && r_hist_valid && hist_ready) begin
      w_we = 1'b1;
    end
  end

  // Bin storage write.
  // NOTE: the bin array is deliberately not reset; CLEAR and read-clear zero it.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Control FSM, increment pipeline, readout registers and sticky error.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    if (reset) begin
      r_state      <= CLEAR;
      r_idx        <= '0;
      r_drain_cnt  <= 1'b0;
      r_in_ready   <= 1'b0;
      r_hist_valid <= 1'b0;
      r_hist_bin   <= '0;
      r_hist_count <= '0;
      r_hist_done  <= 1'b0;
      r_err        <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_bin     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_bin     <= '0;
      r_s2_val     <= '0;
    end else begin
      r_hist_done <= 1'b0;

      r_s1_valid <= w_accept && !w_border;
      r_s1_bin   <= lbp_data;
      r_s2_valid <= r_s1_valid;
      r_s2_bin   <= r_s1_bin;
      r_s2_val   <= w_s1_inc;

      if (r_s1_valid && w_s1_sat) r_err <= 1'b1;
      if (lbp_valid && (!r_in_ready || w_border)) r_err <= 1'b1;

      case (r_state)
        CLEAR: begin
          r_idx <= w_idx_next;
          if (r_idx == LAST_BIN) begin
            r_state    <= ACC;
            r_in_ready <= 1'b1;
          end
        end
        ACC: begin
          if (finish) begin
            r_state     <= DRAIN;
            r_in_ready  <= 1'b0;
            r_drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          r_drain_cnt <= 1'b1;
          if (r_drain_cnt) r_state <= READ;
        end
        READ: begin
          if (!r_hist_valid) begin
            r_hist_valid <= 1'b1;
            r_hist_bin   <= r_idx;
            r_hist_count <= r_mem[r_idx];
          end else if (hist_ready) begin
            r_idx <= w_idx_next;
            if (r_idx == LAST_BIN) begin
              r_hist_valid <= 1'b0;
              r_hist_done  <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_hist_bin   <= w_idx_next;
              r_hist_count <= r_mem[w_idx_next];
            end
          end
        end
        DONE: begin
          if (!finish) begin
            r_state    <= ACC;
            r_in_ready <= 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign hist_valid = r_hist_valid;
  assign hist_bin   = r_hist_bin;
  assign hist_count = r_hist_count;
  assign hist_done  = r_hist_done;
  assign err        = r_err;

endmodule

// File: tb/tb_lbp_hist.sv
// Testbench for lbp_hist: a default-width instance and a 4-bit counter
// instance share all inputs; a bin model builds expected readout words that
// are queued at end of frame and compared as the histograms stream out.
module tb_lbp_hist;

  typedef struct {
    int bin;
    int cnt_a;
    int cnt_b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_ready;

  logic        in_ready_a, hist_valid_a, hist_done_a, err_a;
  logic [7:0]  hist_bin_a;
  logic [13:0] hist_count_a;
  logic        in_ready_b, hist_valid_b, hist_done_b, err_b;
  logic [7:0]  hist_bin_b;
  logic [3:0]  hist_count_b;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   m_a [256];
  int   m_b [256];
  bit   exp_err_a, exp_err_b;
  bit   acc_open;
  exp_t q [$];

  always #5 clk = ~clk;

  lbp_hist u_dut_a (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .in_ready(in_ready_a),
    .hist_valid(hist_valid_a), .hist_ready(hist_ready), .hist_bin(hist_bin_a),
    .hist_count(hist_count_a), .hist_done(hist_done_a), .err(err_a)
  );

  lbp_hist #(.CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .in_ready(in_ready_b),
    .hist_valid(hist_valid_b), .hist_ready(hist_ready), .hist_bin(hist_bin_b),
    .hist_count(hist_count_b), .hist_done(hist_done_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 256; i++) begin
      m_a[i] = 0;
      m_b[i] = 0;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; lbp_valid = 1'b0; finish = 1'b0; hist_ready = 1'b0;
    lbp_addr = '0; lbp_data = '0;
    tick;
    tick;
    check("rst_in_ready",   in_ready_a,   0);
    check("rst_hist_valid", hist_valid_a, 0);
    check("rst_hist_bin",   hist_bin_a,   0);
    check("rst_hist_count", hist_count_a, 0);
    check("rst_hist_done",  hist_done_a,  0);
    check("rst_err",        err_a,        0);
    check("rst_err_b",      err_b,        0);
    reset = 1'b0;
    model_clear();
    exp_err_a = 1'b0;
    exp_err_b = 1'b0;
    acc_open  = 1'b0;
    q.delete();
  endtask

  // Wait out CLEAR, optionally driving samples that must be dropped.
  task automatic clear_wait(input int drop_n);
    for (int i = 0; i < 256; i++) begin
      lbp_valid = (i < drop_n);
      lbp_addr  = {7'd9, 7'd9};
      lbp_data  = 8'h99;
      if (i < drop_n) begin
        exp_err_a = 1'b1;
        exp_err_b = 1'b1;
      end
      if (i == 255) check("in_ready_before_257", in_ready_a, 0);
      tick;
    end
    lbp_valid = 1'b0;
    check("in_ready_at_257", in_ready_a, 1);
    acc_open = 1'b1;
  endtask

  task automatic send(input logic v, input logic [6:0] y, input logic [6:0] x,
                      input logic [7:0] code, input logic fin);
    check("in_ready", in_ready_a, 32'(acc_open));
    lbp_valid = v;
    lbp_addr  = {y, x};
    lbp_data  = code;
    finish    = fin;
    if (v) begin
      if (!acc_open || x == 0 || x == 127 || y == 0 || y == 127) begin
        exp_err_a = 1'b1;
        exp_err_b = 1'b1;
      end else begin
        if (m_a[code] == 16383) exp_err_a = 1'b1; else m_a[code]++;
        if (m_b[code] == 15)    exp_err_b = 1'b1; else m_b[code]++;
      end
    end
    if (acc_open && fin) begin
      acc_open = 1'b0;
      for (int b = 0; b < 256; b++) q.push_back('{b, m_a[b], m_b[b]});
      model_clear();
    end
    tick;
    lbp_valid = 1'b0;
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err_a"}, err_a, 32'(exp_err_a));
    check({tag, "_err_b"}, err_b, 32'(exp_err_b));
  endtask

  // Stream out one histogram, compare against the queue, then leave DONE.
  task automatic read_and_release(input bit rnd);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [7:0]  pb = '0;
    logic [13:0] pc = '0;
    exp_t        e;
    while (got < 256 && cyc < 4000) begin
      if (stalled && hist_valid_a) begin
        check("stall_bin",   hist_bin_a,   pb);
        check("stall_count", hist_count_a, pc);
      end
      hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hist_valid_a && hist_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("word_bin",     hist_bin_a,   e.bin);
          check("word_count",   hist_count_a, e.cnt_a);
          check("word_bin_b",   hist_bin_b,   e.bin);
          check("word_count_b", hist_count_b, e.cnt_b);
        end else begin
          check("unexpected_word", hist_bin_a, 32'hFFFF_FFFF);
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = hist_valid_a;
        pb = hist_bin_a;
        pc = hist_count_a;
      end
      tick;
      cyc++;
    end
    hist_ready = 1'b0;
    if (got < 256) check("read_timeout_words", got, 256);
    check("hist_done_pulse",   hist_done_a,  1);
    check("hist_done_pulse_b", hist_done_b,  1);
    check("valid_after_last",  hist_valid_a, 0);
    tick;
    check("hist_done_one_cycle", hist_done_a, 0);
    check("queue_empty", q.size(), 0);
    finish = 1'b0;
    tick;
    acc_open = 1'b1;
    check("in_ready_after_done", in_ready_a, 1);
  endtask

  initial begin
    do_reset();
    clear_wait(0);

    // Empty frame: 256 zero words then hist_done.
    send(1'b0, 7'd1, 7'd1, 8'h00, 1'b1);
    read_and_release(1'b0);
    check_err("empty");

    // Full interior frame, one code everywhere.
    for (int y = 1; y <= 126; y++)
      for (int x = 1; x <= 126; x++)
        send(1'b1, 7'(y), 7'(x), 8'h55, 1'b0);
    send(1'b0, 7'd1, 7'd1, 8'h00, 1'b1);
    tick;
    tick;
    check_err("full_frame");
    read_and_release(1'b1);

    // Forwarding patterns, then finish held with valid for 20 cycles.
    send(1'b1, 7'd3, 7'd3, 8'h12, 1'b0);
    send(1'b1, 7'd3, 7'd4, 8'h12, 1'b0);
    send(1'b1, 7'd3, 7'd5, 8'h12, 1'b0);
    send(1'b1, 7'd4, 7'd3, 8'h12, 1'b0);
    send(1'b1, 7'd4, 7'd4, 8'h34, 1'b0);
    send(1'b1, 7'd4, 7'd5, 8'h12, 1'b0);
    for (int i = 0; i < 20; i++) send(1'b1, 7'd10, 7'd10, 8'h07, 1'b1);
    read_and_release(1'b1);
    check_err("finish_hold");

    // Border sample alone sets err.
    do_reset();
    clear_wait(0);
    send(1'b1, 7'd0, 7'd5, 8'hBB, 1'b0);
    tick;
    tick;
    check_err("border");

    // Reset mid-ACC, then samples driven during CLEAR are dropped.
    do_reset();
    clear_wait(5);
    check_err("drop_in_clear");

    // Saturation on the 4-bit instance, then a border sample, then readout.
    do_reset();
    clear_wait(0);
    for (int i = 0; i < 16; i++) send(1'b1, 7'd20, 7'(30 + i), 8'hAA, 1'b0);
    tick;
    tick;
    tick;
    check_err("saturate");
    send(1'b1, 7'd0, 7'd5, 8'hBB, 1'b0);
    send(1'b0, 7'd1, 7'd1, 8'h00, 1'b1);
    read_and_release(1'b1);
    check_err("sat_border");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
